// File: rtl/fan_adder_ctrl.sv
// fan_adder_ctrl: command FIFO plus beat sequencer driving one fan_adder reduction unit.
// Define FAN_CTRL_PERF_EN to build the perf_beats/perf_stalls counters; otherwise both read 0.
module fan_adder_ctrl #(
    parameter int DW_DATA   = 8,
    parameter int NUM_IN    = 4,
    parameter int SEL_IN    = 2,
    parameter int CNT_W     = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_add,
    input  logic [SEL_IN*2-1:0]         cmd_sel,
    input  logic [CNT_W-1:0]            cmd_len,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic [DW_DATA*NUM_IN-1:0]   data_in,
    output logic                        fan_add_en,
    output logic                        fan_bypass_en,
    output logic [SEL_IN*2-1:0]         fan_sel,
    output logic [DW_DATA*NUM_IN-1:0]   fan_in,
    output logic                        fan_out_valid,
    output logic                        cmd_done,
    output logic                        busy,
    output logic [31:0]                 perf_beats,
    output logic [31:0]                 perf_stalls
);
    // state | meaning
    // IDLE  | no active command; pops the FIFO head as soon as one is present
    // RUN   | command active; accepts operand beats until the last one
    typedef enum logic {IDLE, RUN} state_t;

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int SW = SEL_IN * 2;

    state_t            state, state_nxt;
    logic              mode_mem [CMD_DEPTH];
    logic [SW-1:0]     sel_mem  [CMD_DEPTH];
    logic [CNT_W-1:0]  len_mem  [CMD_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full, push, pop;
    logic              act_mode;
    logic [SW-1:0]     act_sel;
    logic [CNT_W-1:0]  remaining;
    logic              beat, last_beat;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign data_ready = (state == RUN);
    assign beat       = data_valid && data_ready;
    assign last_beat  = beat && (remaining == '0);
    assign busy       = (state == RUN) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mode_mem[wr_ptr[AW-1:0]] <= cmd_add;
            sel_mem[wr_ptr[AW-1:0]]  <= cmd_sel;
            len_mem[wr_ptr[AW-1:0]]  <= cmd_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_mode      <= 1'b0;
            act_sel       <= '0;
            remaining     <= '0;
            fan_in        <= '0;
            fan_sel       <= '0;
            fan_add_en    <= 1'b0;
            fan_bypass_en <= 1'b0;
            fan_out_valid <= 1'b0;
            cmd_done      <= 1'b0;
        end else begin
            if (pop) begin
                act_mode  <= mode_mem[rd_ptr[AW-1:0]];
                act_sel   <= sel_mem[rd_ptr[AW-1:0]];
                remaining <= len_mem[rd_ptr[AW-1:0]];
            end else if (beat && remaining != '0) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (beat) begin
                fan_in        <= data_in;
                fan_sel       <= act_sel;
                fan_add_en    <= act_mode;
                fan_bypass_en <= !act_mode;
                fan_out_valid <= 1'b1;
                cmd_done      <= last_beat;
            end else begin
                fan_add_en    <= 1'b0;
                fan_bypass_en <= 1'b0;
                fan_out_valid <= 1'b0;
                cmd_done      <= 1'b0;
            end
        end
    end

`ifdef FAN_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (beat && perf_beats != '1)
                perf_beats <= perf_beats + 32'd1;
            if (state == RUN && !data_valid && perf_stalls != '1)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_beats  = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_fan_adder_ctrl.sv
// Bench for fan_adder_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fan_adder_ctrl;
    localparam int CMD_DEPTH = 4;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_add;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        data_valid, data_ready;
    logic [31:0] data_in;
    logic        fan_add_en, fan_bypass_en;
    logic [3:0]  fan_sel;
    logic [31:0] fan_in;
    logic        fan_out_valid, cmd_done, busy;
    logic [31:0] perf_beats, perf_stalls;

    fan_adder_ctrl #(.DW_DATA(8), .NUM_IN(4), .SEL_IN(2), .CNT_W(8), .CMD_DEPTH(CMD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_add(cmd_add),
        .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .fan_add_en(fan_add_en), .fan_bypass_en(fan_bypass_en),
        .fan_sel(fan_sel), .fan_in(fan_in),
        .fan_out_valid(fan_out_valid), .cmd_done(cmd_done), .busy(busy),
        .perf_beats(perf_beats), .perf_stalls(perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a command queue and the active command's beats still owed.
    typedef struct {
        bit          add;
        logic [3:0]  sel;
        int unsigned len;
    } cmd_t;

    cmd_t        q[$];
    bit          m_active;
    bit          m_add;
    logic [3:0]  m_sel;
    int          m_left;
    logic [31:0] e_fan_in;
    logic [3:0]  e_sel;
    bit          e_add, e_byp, e_ov, e_done;
    int unsigned e_beats, e_stalls;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_active = 0; m_add = 0; m_sel = '0; m_left = 0;
            e_fan_in = '0; e_sel = '0;
            e_add = 0; e_byp = 0; e_ov = 0; e_done = 0;
            e_beats = 0; e_stalls = 0;
        end else begin
            bit   beat, can_push;
            cmd_t c;
            can_push = cmd_valid && (q.size() < CMD_DEPTH);
            beat     = data_valid && m_active;
            if (m_active && !data_valid) e_stalls++;
            if (beat) begin
                e_fan_in = data_in;
                e_sel    = m_sel;
                e_add    = m_add;
                e_byp    = !m_add;
                e_ov     = 1;
                m_left--;
                e_done   = (m_left == 0);
                e_beats++;
            end else begin
                e_add = 0; e_byp = 0; e_ov = 0; e_done = 0;
            end
            if (!m_active || (beat && m_left == 0)) begin
                if (q.size() > 0) begin
                    c        = q.pop_front();
                    m_active = 1;
                    m_add    = c.add;
                    m_sel    = c.sel;
                    m_left   = int'(c.len) + 1;
                end else begin
                    m_active = 0;
                end
            end
            if (can_push) begin
                c.add = cmd_add;
                c.sel = cmd_sel;
                c.len = cmd_len;
                q.push_back(c);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", {31'd0, cmd_ready}, {31'd0, q.size() < CMD_DEPTH});
            check("data_ready", {31'd0, data_ready}, {31'd0, m_active});
            check("busy", {31'd0, busy}, {31'd0, m_active || q.size() != 0});
            check("fan_in", fan_in, e_fan_in);
            check("fan_sel", {28'd0, fan_sel}, {28'd0, e_sel});
            check("fan_add_en", {31'd0, fan_add_en}, {31'd0, e_add});
            check("fan_bypass_en", {31'd0, fan_bypass_en}, {31'd0, e_byp});
            check("fan_out_valid", {31'd0, fan_out_valid}, {31'd0, e_ov});
            check("cmd_done", {31'd0, cmd_done}, {31'd0, e_done});
            check("en_exclusive", {31'd0, fan_add_en & fan_bypass_en}, 32'd0);
`ifdef FAN_CTRL_PERF_EN
            check("perf_beats", perf_beats, e_beats);
            check("perf_stalls", perf_stalls, e_stalls);
`else
            check("perf_beats_tied", perf_beats, 32'd0);
            check("perf_stalls_tied", perf_stalls, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_cmd(input bit add, input logic [3:0] sel, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_add = add; cmd_sel = sel; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!data_ready && n < 20) begin
            tick();
            n++;
        end
        check(nm, {31'd0, data_ready}, 32'd1);
    endtask

    logic [4:0]  ov5, byp5, done5;
    logic [3:0]  ov4, add4, byp4, done4;
    logic [31:0] pb0, ps0;
    int          acc, n;
    bit          held_low;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_add = 1'b0; cmd_sel = '0; cmd_len = '0;
        data_valid = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a command drops it silently.
        push_cmd(1'b1, 4'b0101, 8'd5);
        wait_ready("s1_ready");
        data_valid = 1'b1; data_in = 32'hDEADBEEF;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; data_valid = 1'b0;
        check("s1_ov", {31'd0, fan_out_valid}, 32'd0);
        check("s1_done", {31'd0, cmd_done}, 32'd0);
        check("s1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("s1_data_ready", {31'd0, data_ready}, 32'd0);
        check("s1_fan_in", fan_in, 32'd0);
        check("s1_busy", {31'd0, busy}, 32'd0);
        tick();
        check("s1_dropped", {30'd0, busy, cmd_done}, 32'd0);

        // Single-beat add command; data_ready two cycles after handshake.
        push_cmd(1'b1, 4'b1101, 8'd0);
        check("s2_dr_early", {31'd0, data_ready}, 32'd0);
        tick();
        check("s2_dr_2cyc", {31'd0, data_ready}, 32'd1);
        data_valid = 1'b1; data_in = {8'd1, 8'd2, 8'd3, 8'd4};
        tick();
        data_valid = 1'b0;
        check("s2_add_en", {31'd0, fan_add_en}, 32'd1);
        check("s2_sel", {28'd0, fan_sel}, 32'hD);
        check("s2_fan_in", fan_in, 32'h01020304);
        check("s2_ov_done", {30'd0, fan_out_valid, cmd_done}, 32'd3);
        check("s2_idle", {31'd0, data_ready}, 32'd0);

        // Bypass command of three beats with gaps in data_valid.
        push_cmd(1'b0, 4'b0110, 8'd2);
        wait_ready("s3_ready");
        pb0 = perf_beats; ps0 = perf_stalls;
        for (int i = 0; i < 5; i++) begin
            data_valid = (i % 2 == 0);
            data_in = 32'hA0 + i;
            tick();
            ov5[i] = fan_out_valid; byp5[i] = fan_bypass_en; done5[i] = cmd_done;
        end
        data_valid = 1'b0;
        check("s3_ov", {27'd0, ov5}, 32'b10101);
        check("s3_byp", {27'd0, byp5}, 32'b10101);
        check("s3_done", {27'd0, done5}, 32'b10000);
`ifdef FAN_CTRL_PERF_EN
        check("s3_stalls", perf_stalls - ps0, 32'd2);
        check("s3_beats", perf_beats - pb0, 32'd3);
`endif

        // Back-to-back commands stream without a bubble.
        data_valid = 1'b1; data_in = 32'h11;
        cmd_valid = 1'b1; cmd_add = 1'b1; cmd_sel = 4'b0001; cmd_len = 8'd1;
        tick();
        cmd_add = 1'b0; cmd_sel = 4'b1010; cmd_len = 8'd1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = 32'h20 + i;
            tick();
            ov4[i] = fan_out_valid; add4[i] = fan_add_en; byp4[i] = fan_bypass_en; done4[i] = cmd_done;
        end
        data_valid = 1'b0;
        check("s4_ov", {28'd0, ov4}, 32'b1111);
        check("s4_add", {28'd0, add4}, 32'b0011);
        check("s4_byp", {28'd0, byp4}, 32'b1100);
        check("s4_done", {28'd0, done4}, 32'b1010);
        check("s4_sel", {28'd0, fan_sel}, 32'b1010);
        check("s4_fan_in", fan_in, 32'h23);

        // Fill the FIFO while no data arrives.
        cmd_valid = 1'b1; cmd_add = 1'b1; cmd_sel = 4'b0011; cmd_len = 8'd0;
        acc = 0;
        while (cmd_ready && acc < 10) begin
            tick();
            acc++;
        end
        check("s5_accepted", acc, 32'd5);
        held_low = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cmd_ready) held_low = 1'b0;
        end
        check("s5_held_full", {31'd0, held_low}, 32'd1);
        data_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("s5_slot_freed", {31'd0, cmd_ready}, 32'd1);
        check("s5_done", {31'd0, cmd_done}, 32'd1);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("s5_drained", {31'd0, busy}, 32'd0);
        data_valid = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
